// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the run/stop/clear display counter controller:
// FSM state encoding, count direction values and default limits.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  localparam int DEFAULT_COUNT_MAX = 9999;
  localparam int COUNT_W           = 14;

endpackage

// File: rtl/tick_gen_en.sv
// Enable-gated prescaler: emits a one-cycle tick every F_DIV enabled cycles
// and restarts from zero whenever the enable drops.
module tick_gen_en #(
  parameter int F_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int            W    = (F_DIV > 1) ? $clog2(F_DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(F_DIV - 1);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (!i_en || (cnt_reg == LAST)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign o_tick = i_en && (cnt_reg == LAST);

endmodule

// File: rtl/count_run_ctrl.sv
// Run/stop/clear controller driving the 0..COUNT_MAX display counter from
// single-cycle button pulses, with a prescaled count-enable tick.
module count_run_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int F_DIV     = 10_000_000,
  parameter int COUNT_MAX = DEFAULT_COUNT_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_btn_run,
  input  logic               i_btn_clear,
  input  logic               i_btn_mode,
  output logic [COUNT_W-1:0] o_counter,
  output logic               o_run,
  output logic               o_mode,
  output logic               o_tick
);

  localparam logic [COUNT_W-1:0] CMAX = COUNT_W'(COUNT_MAX);

  state_t             state_reg, state_next;
  logic               mode_reg, mode_next;
  logic [COUNT_W-1:0] counter_reg, counter_next;
  logic               tick;

  tick_gen_en #(
    .F_DIV (F_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_en   (state_reg == ST_RUN),
    .o_tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_STOP;
      mode_reg    <= MODE_UP;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      counter_reg <= counter_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    counter_next = counter_reg;

    // Clear outranks run; CLEAR is a single-cycle state that ignores run/clear.
    case (state_reg)
      ST_STOP:  if (i_btn_clear) state_next = ST_CLEAR;
                else if (i_btn_run) state_next = ST_RUN;
      ST_RUN:   if (i_btn_clear) state_next = ST_CLEAR;
                else if (i_btn_run) state_next = ST_STOP;
      ST_CLEAR: state_next = ST_STOP;
      default:  state_next = ST_STOP;
    endcase

    if (i_btn_mode) begin
      mode_next = ~mode_reg;
    end

    // The tick uses the registered direction, so a coincident mode pulse waits.
    if (state_reg == ST_CLEAR) begin
      counter_next = '0;
    end else if (tick) begin
      if (mode_reg == MODE_UP) begin
        counter_next = (counter_reg >= CMAX) ? '0 : counter_reg + COUNT_W'(1);
      end else begin
        counter_next = (counter_reg == '0 || counter_reg > CMAX) ? CMAX
                                                                : counter_reg - COUNT_W'(1);
      end
    end
  end

  assign o_counter = counter_reg;
  assign o_run     = (state_reg == ST_RUN);
  assign o_mode    = mode_reg;
  assign o_tick    = tick;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Directed bench for count_run_ctrl: expected post-tick counter values are
// queued by the stimulus and popped by a monitor on every observed tick.
module tb_count_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_btn_run;
  logic        i_btn_clear;
  logic        i_btn_mode;
  logic [13:0] o_counter;
  logic        o_run;
  logic        o_mode;
  logic        o_tick;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  logic tick_seen = 1'b0;

  count_run_ctrl #(
    .F_DIV     (4),
    .COUNT_MAX (9999)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_btn_run   (i_btn_run),
    .i_btn_clear (i_btn_clear),
    .i_btn_mode  (i_btn_mode),
    .o_counter   (o_counter),
    .o_run       (o_run),
    .o_mode      (o_mode),
    .o_tick      (o_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  task automatic press(input logic r, input logic c, input logic m);
    @(posedge clk); #1;
    i_btn_run = r; i_btn_clear = c; i_btn_mode = m;
    @(posedge clk); #1;
    i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_mode = 1'b0;
  endtask

  // Returns at the falling edge of the n-th tick seen; bounded.
  task automatic wait_ticks(input int n, input string name);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * 8 + 16) begin
      @(negedge clk);
      cyc++;
      if (o_tick) seen++;
    end
    chk(name, seen, n);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) exp_q.push_back(v);
  endtask

  // Scoreboard monitor: one cycle after each tick the counter must match the queue head.
  always @(negedge clk) begin
    if (reset) begin
      tick_seen <= 1'b0;
    end else begin
      if (tick_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra_tick counter=%0d required=no_tick", o_counter);
        end else begin
          chk("sb_tick_result", int'(o_counter), exp_q.pop_front());
        end
      end
      tick_seen <= o_tick;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first;
    int nt;

    reset = 1'b1; i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      {i_btn_run, i_btn_clear, i_btn_mode} = 3'($urandom);
      @(negedge clk);
      chk("reset_outputs", int'({o_counter, o_run, o_mode, o_tick}), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_mode = 1'b0;
    @(negedge clk);
    chk("after_reset_outputs", int'({o_counter, o_run, o_mode, o_tick}), 0);

    // Run for 40 cycles: tick on the 4th RUN cycle, 10 ticks total.
    push_range(1, 10);
    press(1'b1, 1'b0, 1'b0);
    first = 0; nt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) chk("run_asserted", int'(o_run), 1);
      if (o_tick) begin
        nt++;
        if (first == 0) first = k;
      end
    end
    chk("first_tick_cycle", first, 4);
    chk("tick_count_40", nt, 10);
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("stopped_run", int'(o_run), 0);
    chk("stopped_counter", int'(o_counter), 10);

    // Clear from STOP: old value during CLEAR, zero after.
    press(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("clear_state_counter", int'(o_counter), 10);
    @(negedge clk);
    chk("clear_done_counter", int'(o_counter), 0);

    // Wrap checks: down 0->9999->9998, up ->9999->0, down ->9999.
    press(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("mode_down", int'(o_mode), 1);
    exp_q.push_back(9999); exp_q.push_back(9998);
    press(1'b1, 1'b0, 1'b0);
    wait_ticks(2, "ticks_down_wrap");
    press(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("mode_up", int'(o_mode), 0);
    exp_q.push_back(9999); exp_q.push_back(0);
    wait_ticks(2, "ticks_up_wrap");
    press(1'b0, 1'b0, 1'b1);
    exp_q.push_back(9999);
    wait_ticks(1, "ticks_down_again");
    press(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_clear_counter", int'(o_counter), 0);
    press(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("mode_up_restored", int'(o_mode), 0);

    // Clear coincident with the tick at value 5.
    push_range(1, 6);
    press(1'b1, 1'b0, 1'b0);
    wait_ticks(5, "ticks_to_5");
    wait_ticks(1, "tick_at_5");
    chk("pre_clear_counter", int'(o_counter), 5);
    i_btn_clear = 1'b1;
    @(posedge clk); #1;
    i_btn_clear = 1'b0;
    @(negedge clk);
    chk("clear_tick_counter", int'(o_counter), 6);
    chk("clear_tick_run", int'(o_run), 0);
    @(negedge clk);
    chk("clear_tick_final", int'(o_counter), 0);
    chk("clear_tick_stop", int'(o_run), 0);

    // Run pulse coincident with the tick at value 7.
    push_range(1, 8);
    press(1'b1, 1'b0, 1'b0);
    wait_ticks(8, "ticks_to_7");
    chk("pre_stop_counter", int'(o_counter), 7);
    i_btn_run = 1'b1;
    @(posedge clk); #1;
    i_btn_run = 1'b0;
    @(negedge clk);
    chk("stop_tick_counter", int'(o_counter), 8);
    chk("stop_tick_run", int'(o_run), 0);
    nt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_tick) nt++;
    end
    chk("no_ticks_stopped", nt, 0);
    chk("held_counter", int'(o_counter), 8);

    // Reset mid-RUN at 123, with buttons asserted during the reset edge.
    push_range(9, 123);
    press(1'b1, 1'b0, 1'b0);
    wait_ticks(115, "ticks_to_123");
    @(negedge clk);
    chk("pre_reset_counter", int'(o_counter), 123);
    @(negedge clk);
    chk("pre_reset_run", int'(o_run), 1);
    reset = 1'b1; i_btn_run = 1'b1; i_btn_clear = 1'b1; i_btn_mode = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; i_btn_run = 1'b0; i_btn_clear = 1'b0; i_btn_mode = 1'b0;
    @(negedge clk);
    chk("midrun_reset_outputs", int'({o_counter, o_run, o_mode, o_tick}), 0);
    exp_q.push_back(1);
    press(1'b1, 1'b0, 1'b0);
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      @(negedge clk);
      if (o_tick) first = k;
    end
    chk("post_reset_first_tick", first, 4);
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("final_counter", int'(o_counter), 1);
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
